mmult_tile_ctrl: RTL and testbench

Next-generation control unit for the matrix-multiplier datapath. It sequences row fetch, row load, column-tile fetch and PE issue across LANES parallel PEs, so each issue covers up to LANES columns. Output dimensions are set per run at start, bounded by N_MAX/M_MAX. Adds abort, a busy flag, a config-error flag and a drain phase that waits for all lanes to finish.

---
 rtl/mmult_pkg.sv | 19 +
 rtl/mmult_lane_mask.sv | 25 ++
 rtl/mmult_tile_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mmult_tile_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmult_pkg.sv
// Shared types and helpers for the matrix-multiplier tile controller.
package mmult_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH_ROW = 4'd1,
        LOAD_ROW  = 4'd2,
        FETCH_COL = 4'd3,
        ISSUE     = 4'd4,
        ADVANCE   = 4'd5,
        DRAIN     = 4'd6,
        DONE_ST   = 4'd7
    } mmult_state_t;

    function automatic int idx_w(input int max_v);
        return (max_v > 2) ? $clog2(max_v) : 1;
    endfunction

endpackage

// File: rtl/mmult_lane_mask.sv
// Active-lane mask for a column tile: lane i is live while its
// column (base + i) is still inside the configured width.
module mmult_lane_mask
    import mmult_pkg::*;
#(
    parameter int M_MAX = 4,
    parameter int LANES = 2,
    localparam int MW = idx_w(M_MAX)
) (
    input  logic [MW-1:0]    col_idx_i,
    input  logic [MW-1:0]    cols_m1_i,
    output logic [LANES-1:0] mask_o
);

    // One extra bit so base + lane never wraps past M_MAX.
    localparam int SW = MW + 1;

    always_comb begin
        mask_o = '0;
        for (int i = 0; i < LANES; i++) begin
            mask_o[i] = (SW'(col_idx_i) + SW'(i)) <= SW'(cols_m1_i);
        end
    end

endmodule

// File: rtl/mmult_tile_ctrl.sv
// Tile sequencer for the matrix-multiplier datapath: walks rows and
// LANES-wide column tiles, issues PE starts, then drains before done.
module mmult_tile_ctrl
    import mmult_pkg::*;
#(
    parameter int N_MAX = 4,
    parameter int M_MAX = 4,
    parameter int LANES = 2,
    localparam int NW = idx_w(N_MAX),
    localparam int MW = idx_w(M_MAX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [NW-1:0]    cfg_rows_m1,
    input  logic [MW-1:0]    cfg_cols_m1,
    input  logic             fetch_stall,
    input  logic             data_stall,
    input  logic             fifo_full,
    input  logic [LANES-1:0] pe_ready,
    output logic             fetch_row,
    output logic             load_row,
    output logic             fetch_col,
    output logic [LANES-1:0] start_pe,
    output logic [NW-1:0]    row_idx,
    output logic [MW-1:0]    col_idx,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    localparam int SW = MW + 1;

    mmult_state_t state_q, state_d;

    logic [NW-1:0]    rows_q, rows_d;
    logic [NW-1:0]    row_q, row_d;
    logic [MW-1:0]    cols_q, cols_d;
    logic [MW-1:0]    col_q, col_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [LANES-1:0] mask;
    logic [SW-1:0]    col_sum;
    logic             cfg_bad;
    logic             last_tile;
    logic             last_row;
    logic             can_issue;

    mmult_lane_mask #(
        .M_MAX (M_MAX),
        .LANES (LANES)
    ) u_lane_mask (
        .col_idx_i (col_q),
        .cols_m1_i (cols_q),
        .mask_o    (mask)
    );

    assign cfg_bad   = (int'(cfg_rows_m1) >= N_MAX)
                    || (int'(cfg_cols_m1) >= M_MAX);
    assign col_sum   = SW'(col_q) + SW'(LANES);
    assign last_tile = col_sum > SW'(cols_q);
    assign last_row  = row_q == rows_q;

    // Idle lanes beyond the matrix edge must not hold up the issue.
    assign can_issue = ((pe_ready & mask) == mask)
                    && !fifo_full && !data_stall;

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        row_d     = row_q;
        col_d     = col_q;
        done_d    = done_q;
        err_d     = err_q;
        fetch_row = 1'b0;
        load_row  = 1'b0;
        fetch_col = 1'b0;
        start_pe  = '0;

        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE_ST: begin
                    if (start) begin
                        rows_d = cfg_rows_m1;
                        cols_d = cfg_cols_m1;
                        done_d = 1'b0;
                        if (cfg_bad) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            err_d   = 1'b0;
                            row_d   = '0;
                            col_d   = '0;
                            state_d = FETCH_ROW;
                        end
                    end
                end
                FETCH_ROW: begin
                    if (!fetch_stall) begin
                        fetch_row = 1'b1;
                        state_d   = LOAD_ROW;
                    end
                end
                LOAD_ROW: begin
                    if (!data_stall) begin
                        load_row = 1'b1;
                        state_d  = FETCH_COL;
                    end
                end
                FETCH_COL: begin
                    if (!fetch_stall) begin
                        fetch_col = 1'b1;
                        state_d   = ISSUE;
                    end
                end
                ISSUE: begin
                    if (can_issue) begin
                        start_pe = mask;
                        state_d  = ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (last_tile && last_row) begin
                        state_d = DRAIN;
                    end else if (last_tile) begin
                        col_d   = '0;
                        row_d   = row_q + NW'(1);
                        state_d = FETCH_ROW;
                    end else begin
                        col_d   = col_sum[MW-1:0];
                        state_d = FETCH_COL;
                    end
                end
                DRAIN: begin
                    if (&pe_ready) begin
                        done_d  = 1'b1;
                        state_d = DONE_ST;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rows_q  <= '0;
            cols_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy    = (state_q != IDLE) && (state_q != DONE_ST) && !abort;
    assign row_idx = row_q;
    assign col_idx = col_q;
    assign done    = done_q;
    assign cfg_err = err_q;

endmodule

// File: tb/tb_mmult_tile_ctrl.sv
// Randomised and directed bench for mmult_tile_ctrl, scored against an
// event-queue model of the expected run, plus a small-config instance.
module tb_mmult_tile_ctrl;

    localparam int N_MAX = 4;
    localparam int M_MAX = 4;
    localparam int LANES = 2;
    localparam int NW    = 2;
    localparam int MW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, abort;
    logic [NW-1:0]    rows;
    logic [MW-1:0]    cols;
    logic             fetch_stall, data_stall, fifo_full;
    logic [LANES-1:0] pe_ready;
    logic             fetch_row, load_row, fetch_col;
    logic [LANES-1:0] start_pe;
    logic [NW-1:0]    row_idx;
    logic [MW-1:0]    col_idx;
    logic             busy, done, cfg_err;

    logic             start2;
    logic [1:0]       rows2, cols2;
    logic             fr2, lr2, fc2;
    logic [0:0]       spe2;
    logic [1:0]       ri2, ci2;
    logic             busy2, done2, err2;

    always #5 clk = ~clk;

    mmult_tile_ctrl #(.N_MAX(N_MAX), .M_MAX(M_MAX), .LANES(LANES)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_rows_m1(rows), .cfg_cols_m1(cols),
        .fetch_stall(fetch_stall), .data_stall(data_stall),
        .fifo_full(fifo_full), .pe_ready(pe_ready),
        .fetch_row(fetch_row), .load_row(load_row), .fetch_col(fetch_col),
        .start_pe(start_pe), .row_idx(row_idx), .col_idx(col_idx),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    mmult_tile_ctrl #(.N_MAX(3), .M_MAX(3), .LANES(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
        .cfg_rows_m1(rows2), .cfg_cols_m1(cols2),
        .fetch_stall(1'b0), .data_stall(1'b0),
        .fifo_full(1'b0), .pe_ready(1'b1),
        .fetch_row(fr2), .load_row(lr2), .fetch_col(fc2),
        .start_pe(spe2), .row_idx(ri2), .col_idx(ci2),
        .busy(busy2), .done(done2), .cfg_err(err2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Expected run as an ordered list of pulses: 0 fetch_row,
    // 1 load_row, 2 fetch_col, 3 start_pe.
    typedef struct {
        int               kind;
        int               row;
        int               col;
        logic [LANES-1:0] mask;
    } ev_t;

    ev_t  q[$];
    bit   m_active, m_gap, m_drain, m_done, m_err;
    int   m_row, m_col;
    bit   fire;
    logic e_fr, e_lr, e_fc;
    logic [LANES-1:0] e_spe;

    int   n_iss, n_fc, n_pulse, done_cyc;
    logic [LANES-1:0] masks[$];
    int   iss_cyc[$], iss_row[$], iss_col[$], fc_cyc[$];
    logic done_prev;
    int   n_iss2 = 0;

    task automatic build_run(input int r, input int c);
        ev_t e;
        q.delete();
        for (int rr = 0; rr <= r; rr++) begin
            e.kind = 0; e.row = rr; e.col = 0; e.mask = '0;
            q.push_back(e);
            e.kind = 1;
            q.push_back(e);
            for (int cc = 0; cc <= c; cc += LANES) begin
                e.kind = 2; e.row = rr; e.col = cc; e.mask = '0;
                q.push_back(e);
                for (int i = 0; i < LANES; i++) e.mask[i] = (cc + i <= c);
                e.kind = 3;
                q.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_active = 0; m_gap = 0; m_drain = 0;
            m_done = 0; m_err = 0; m_row = 0; m_col = 0;
            done_prev = 0;
        end else begin
            e_fr = 0; e_lr = 0; e_fc = 0; e_spe = '0; fire = 0;
            if (!abort && m_active && !m_gap && !m_drain && q.size() > 0) begin
                case (q[0].kind)
                    0: fire = !fetch_stall;
                    1: fire = !data_stall;
                    2: fire = !fetch_stall;
                    default: fire = ((pe_ready & q[0].mask) == q[0].mask)
                                    && !fifo_full && !data_stall;
                endcase
                if (fire) begin
                    case (q[0].kind)
                        0: e_fr = 1;
                        1: e_lr = 1;
                        2: e_fc = 1;
                        default: e_spe = q[0].mask;
                    endcase
                end
            end
            chk("fetch_row", fetch_row, e_fr);
            chk("load_row", load_row, e_lr);
            chk("fetch_col", fetch_col, e_fc);
            chk("start_pe", start_pe, e_spe);
            chk("busy", busy, m_active && !abort);
            chk("done", done, m_done);
            chk("cfg_err", cfg_err, m_err);
            chk("row_idx", row_idx, m_row);
            chk("col_idx", col_idx, m_col);

            if (start_pe != 0) begin
                n_iss++;
                masks.push_back(start_pe);
                iss_cyc.push_back(cyc);
                iss_row.push_back(int'(row_idx));
                iss_col.push_back(int'(col_idx));
            end
            if (fetch_col) begin
                n_fc++;
                fc_cyc.push_back(cyc);
            end
            if (fetch_row || load_row || fetch_col || start_pe != 0)
                n_pulse++;
            if (done && !done_prev) done_cyc = cyc;
            done_prev = done;

            if (abort) begin
                m_active = 0; m_gap = 0; m_drain = 0;
                q.delete();
            end else if (!m_active) begin
                if (start) begin
                    m_done = 0;
                    if (int'(rows) >= N_MAX || int'(cols) >= M_MAX) begin
                        m_err = 1;
                    end else begin
                        m_err = 0; m_row = 0; m_col = 0;
                        m_active = 1; m_gap = 0; m_drain = 0;
                        build_run(int'(rows), int'(cols));
                    end
                end
            end else if (m_drain) begin
                if (&pe_ready) begin
                    m_done = 1; m_active = 0; m_drain = 0;
                end
            end else if (m_gap) begin
                m_gap = 0;
                if (q.size() == 0) begin
                    m_drain = 1;
                end else begin
                    m_row = q[0].row;
                    m_col = q[0].col;
                end
            end else if (fire) begin
                if (q[0].kind == 3) m_gap = 1;
                void'(q.pop_front());
            end
        end
    end

    always @(negedge clk) if (!rst && spe2 != 0) n_iss2++;

    int t0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        n_iss = 0; n_fc = 0; n_pulse = 0; done_cyc = -1;
        masks.delete(); iss_cyc.delete(); iss_row.delete();
        iss_col.delete(); fc_cyc.delete();
    endtask

    task automatic do_start(input int r, input int c);
        rows  = NW'(r);
        cols  = MW'(c);
        start = 1;
        t0    = cyc;
        step();
        start = 0;
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; rows = '0; cols = '0;
        fetch_stall = 0; data_stall = 0; fifo_full = 0; pe_ready = '0;
        start2 = 0; rows2 = '0; cols2 = '0;
        clear_stats();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_pulses", {fetch_row, load_row, fetch_col, start_pe}, 0);
        chk("rst_idx", {row_idx, col_idx}, 0);
        #1 rst = 0;
        pe_ready = 2'b11;
        step();

        // Full 4x4, no stalls.
        clear_stats();
        do_start(3, 3);
        repeat (40) step();
        chk("A_issues", n_iss, 8);
        for (int k = 0; k < n_iss && k < 8; k++) begin
            chk("A_mask", masks[k], 2'b11);
            chk("A_row", iss_row[k], k / 2);
            chk("A_col", iss_col[k], (k % 2) * 2);
        end
        if (n_iss > 0) chk("A_first_lat", iss_cyc[0] - t0, 4);
        if (n_iss > 1) chk("A_tile_lat", iss_cyc[1] - iss_cyc[0], 3);
        if (n_iss > 2) chk("A_row_lat", iss_cyc[2] - iss_cyc[1], 5);
        chk("A_done_lat", done_cyc - t0, 34);

        // Partial last tile.
        clear_stats();
        do_start(0, 2);
        repeat (15) step();
        chk("B_issues", n_iss, 2);
        if (n_iss == 2) begin
            chk("B_mask0", masks[0], 2'b11);
            chk("B_mask1", masks[1], 2'b01);
        end
        chk("B_fetch_col", n_fc, 2);

        // fetch_stall across FETCH_COL.
        clear_stats();
        do_start(0, 0);
        repeat (2) step();
        fetch_stall = 1;
        repeat (5) step();
        fetch_stall = 0;
        repeat (8) step();
        chk("C_fetch_col", n_fc, 1);
        if (n_fc == 1) chk("C_fc_cyc", fc_cyc[0] - t0, 8);

        // Not-ready active lane blocks the issue.
        clear_stats();
        pe_ready = 2'b10;
        do_start(0, 1);
        repeat (6) step();
        pe_ready = 2'b11;
        repeat (6) step();
        chk("D_issues", n_iss, 1);
        if (n_iss == 1) chk("D_iss_cyc", iss_cyc[0] - t0, 7);

        // Inactive lane is ignored at issue; drain waits for all lanes.
        clear_stats();
        pe_ready = 2'b01;
        do_start(0, 0);
        repeat (8) step();
        pe_ready = 2'b11;
        repeat (4) step();
        if (n_iss == 1) chk("D2_iss_cyc", iss_cyc[0] - t0, 4);
        chk("D2_done_lat", done_cyc - t0, 10);

        // fifo_full blocks the issue.
        clear_stats();
        do_start(0, 1);
        repeat (3) step();
        fifo_full = 1;
        repeat (2) step();
        fifo_full = 0;
        repeat (6) step();
        if (n_iss == 1) chk("E_iss_cyc", iss_cyc[0] - t0, 6);
        chk("E_issues", n_iss, 1);

        // Abort in ADVANCE.
        clear_stats();
        do_start(3, 3);
        repeat (4) step();
        abort = 1;
        step();
        abort = 0;
        n_pulse = 0;
        repeat (10) step();
        chk("F_pulses", n_pulse, 0);
        chk("F_done", done, 0);
        chk("F_busy", busy, 0);

        // start and abort together in IDLE.
        abort = 1;
        do_start(0, 0);
        abort = 0;
        @(negedge clk);
        chk("F_start_abort_busy", busy, 0);
        step();

        clear_stats();
        do_start(1, 1);
        repeat (20) step();
        chk("G_issues", n_iss, 2);
        if (n_iss == 2) begin
            chk("G_tile0", {iss_row[0][7:0], iss_col[0][7:0]}, 16'h0000);
            chk("G_tile1", {iss_row[1][7:0], iss_col[1][7:0]}, 16'h0100);
        end
        chk("G_done_lat", done_cyc - t0, 12);

        // Random traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            fetch_stall = ($urandom % 4) == 0;
            data_stall  = ($urandom % 5) == 0;
            fifo_full   = ($urandom % 6) == 0;
            pe_ready    = (($urandom % 3) == 0) ? LANES'($urandom) : '1;
            abort       = ($urandom % 150) == 0;
            start       = ($urandom % 8) == 0;
            rows        = NW'($urandom);
            cols        = MW'($urandom);
            step();
        end
        start = 0; abort = 0; fetch_stall = 0; data_stall = 0;
        fifo_full = 0; pe_ready = '1;
        repeat (5) step();

        // Second instance: 3x3, one lane, config error path.
        n_iss2 = 0;
        rows2  = 2'd2;
        cols2  = 2'd2;
        start2 = 1;
        t0     = cyc;
        step();
        start2 = 0;
        repeat (33) step();
        @(negedge clk);
        chk("H_done_early", done2, 0);
        chk("H_busy_drain", busy2, 1);
        step();
        @(negedge clk);
        chk("H_done", done2, 1);
        chk("H_busy_end", busy2, 0);
        chk("H_issues", n_iss2, 9);

        rows2 = 2'd3; cols2 = 2'd0; start2 = 1;
        step();
        start2 = 0;
        @(negedge clk);
        chk("H_err_rows", err2, 1);
        chk("H_err_done", done2, 0);
        chk("H_err_busy", busy2, 0);
        step();

        rows2 = 2'd0; cols2 = 2'd3; start2 = 1;
        step();
        start2 = 0;
        @(negedge clk);
        chk("H_err_cols", err2, 1);
        chk("H_err_busy2", busy2, 0);
        step();

        rows2 = 2'd0; cols2 = 2'd0; start2 = 1;
        step();
        start2 = 0;
        @(negedge clk);
        chk("H_err_clear", err2, 0);
        chk("H_busy_run", busy2, 1);
        repeat (10) step();
        chk("H_done2", done2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
